// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with grant locking: an owner keeps the shared port
// until it releases, or until its hold budget expires while someone else waits.
module rr_lock_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  // state | meaning
  // IDLE  | no grant outstanding
  // BUSY  | grant_id owns the port; hold_cnt counts its consecutive cycles

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  req_oth;
  logic          others;
  logic          ptr_hit, pre_hit;
  logic [IW-1:0] ptr_win, pre_win, pi, oi;
  logic          do_issue, do_idle;
  logic [IW-1:0] win;
  logic [HW-1:0] hold_nxt;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    nxt = (i == IW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign req_oth = req & ~grant;
  assign others  = |req_oth;

  // ptr search is used for fresh and release arbitration; the owner-masked
  // search starting after the owner is used for preemption.
  always_comb begin
    ptr_hit = 1'b0;
    ptr_win = '0;
    pre_hit = 1'b0;
    pre_win = '0;
    pi      = '0;
    oi      = '0;
    for (int k = 0; k < N; k++) begin
      pi = IW'((int'(ptr) + k) % N);
      oi = IW'((int'(grant_id) + 1 + k) % N);
      if (!ptr_hit && req[pi]) begin
        ptr_hit = 1'b1;
        ptr_win = pi;
      end
      if (!pre_hit && req_oth[oi]) begin
        pre_hit = 1'b1;
        pre_win = oi;
      end
    end
  end

  always_comb begin
    do_issue = 1'b0;
    do_idle  = 1'b0;
    win      = ptr_win;
    hold_nxt = hold_cnt;
    case (state)
      IDLE: do_issue = ptr_hit;
      BUSY: begin
        if (!req[grant_id]) begin
          do_issue = ptr_hit;
          do_idle  = !ptr_hit;
        end else if (MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD) && others) begin
          do_issue = 1'b1;
          win      = pre_win;
        end else if (!others) begin
          hold_nxt = HW'(1);
        end else if (MAX_HOLD != 0 && hold_cnt != HW'(MAX_HOLD)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: do_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else if (do_issue) begin
      state       <= BUSY;
      grant       <= onehot(win);
      grant_valid <= 1'b1;
      grant_id    <= win;
      ptr         <= nxt(win);
      hold_cnt    <= HW'(1);
    end else if (do_idle) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= '0;
    end else begin
      hold_cnt    <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: three configurations run against a behavioural
// owner/pointer model, plus directed sequences on the N=2 instance.
module tb_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_v [3];

  logic [1:0] req_a;
  logic [2:0] req_b, req_c;
  logic [1:0] g_a;
  logic [2:0] g_b, g_c;
  logic       v_a, v_b, v_c;
  logic       id_a;
  logic [1:0] id_b, id_c;

  assign req_a = req_v[0][1:0];
  assign req_b = req_v[1][2:0];
  assign req_c = req_v[2][2:0];

  rr_lock_arbiter #(.N(2), .MAX_HOLD(4)) u_a (.clk(clk), .reset(rst), .req(req_a),
    .grant(g_a), .grant_valid(v_a), .grant_id(id_a));
  rr_lock_arbiter #(.N(3), .MAX_HOLD(0)) u_b (.clk(clk), .reset(rst), .req(req_b),
    .grant(g_b), .grant_valid(v_b), .grant_id(id_b));
  rr_lock_arbiter #(.N(3), .MAX_HOLD(2)) u_c (.clk(clk), .reset(rst), .req(req_c),
    .grant(g_c), .grant_valid(v_c), .grant_id(id_c));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int n_of [3] = '{2, 3, 3};
  int m_of [3] = '{4, 0, 2};
  int own  [3];
  int ptr  [3];
  int hold [3];
  int wait_c [3][3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start, input int n, input int excl);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (start + k) % n;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic take(input int k, input int w);
    own[k]  = w;
    ptr[k]  = (w + 1) % n_of[k];
    hold[k] = 1;
  endtask

  // Round-robin lock rules: release re-arbitrates, budget expiry under
  // contention hands off to the next waiter after the owner.
  task automatic model_step(input int k, input bit r_i);
    logic [3:0] r;
    int w;
    bit oth;
    r = req_v[k];
    if (r_i) begin
      own[k] = -1; ptr[k] = 0; hold[k] = 0;
    end else if (own[k] < 0) begin
      w = first_from(r, ptr[k], n_of[k], -1);
      if (w >= 0) take(k, w);
    end else if (!r[own[k]]) begin
      w = first_from(r, ptr[k], n_of[k], -1);
      if (w >= 0) take(k, w);
      else begin own[k] = -1; hold[k] = 0; end
    end else begin
      oth = (first_from(r, 0, n_of[k], own[k]) >= 0);
      if (m_of[k] != 0 && hold[k] == m_of[k] && oth)
        take(k, first_from(r, (own[k] + 1) % n_of[k], n_of[k], own[k]));
      else if (!oth) hold[k] = 1;
      else if (hold[k] < m_of[k]) hold[k]++;
    end
  endtask

  task automatic cyc();
    logic [3:0] g [3];
    logic [3:0] id [3];
    logic       v [3];
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, rst);
    #1;
    g[0] = {2'b0, g_a}; g[1] = {1'b0, g_b}; g[2] = {1'b0, g_c};
    id[0] = {3'b0, id_a}; id[1] = {2'b0, id_b}; id[2] = {2'b0, id_c};
    v[0] = v_a; v[1] = v_b; v[2] = v_c;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("grant%0d", k), g[k], (own[k] < 0) ? 0 : (1 << own[k]));
      check_eq($sformatf("valid%0d", k), v[k], own[k] >= 0);
      check_eq($sformatf("id%0d", k), id[k], (own[k] < 0) ? 0 : own[k]);
      check_eq($sformatf("onehot%0d", k), $onehot0(g[k]), 1);
      if (m_of[k] != 0) begin
        for (int i = 0; i < n_of[k]; i++) begin
          if (!rst && req_v[k][i] && !g[k][i]) wait_c[k][i]++;
          else wait_c[k][i] = 0;
          check_eq($sformatf("starve%0d_%0d", k, i),
                   wait_c[k][i] <= (n_of[k] - 1) * m_of[k] + 1, 1);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      own[k] = -1; ptr[k] = 0; hold[k] = 0;
      for (int i = 0; i < 3; i++) wait_c[k][i] = 0;
    end
    rst = 1'b1;
    req_v[0] = 4'b0011; req_v[1] = 4'b0111; req_v[2] = 4'b0111;

    // reset held with requests pending
    repeat (2) begin
      cyc();
      check_eq("rst_grant", g_a, 2'b00);
      check_eq("rst_valid", v_a, 1'b0);
    end
    rst = 1'b0;

    // contention from reset release: 4 cycles each, alternating
    for (int i = 0; i < 16; i++) begin
      cyc();
      check_eq("contend", g_a, ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("contend_valid", v_a, 1'b1);
      if (i == 0) check_eq("first_id", id_a, 1'b0);
    end

    // lone request then drop
    req_v[0] = 4'b0001;
    repeat (3) begin
      cyc();
      check_eq("lone", g_a, 2'b01);
    end
    req_v[0] = 4'b0000;
    cyc();
    check_eq("drop_grant", g_a, 2'b00);
    check_eq("drop_valid", v_a, 1'b0);

    // lone owner is never preempted
    req_v[0] = 4'b0001;
    repeat (10) begin
      cyc();
      check_eq("no_contender", g_a, 2'b01);
    end

    // release handoff without idle bubble
    req_v[0] = 4'b0011;
    repeat (2) begin
      cyc();
      check_eq("pre_handoff", g_a, 2'b01);
    end
    req_v[0] = 4'b0010;
    cyc();
    check_eq("handoff", g_a, 2'b10);

    // reset mid-grant, then pointer back at 0
    rst = 1'b1;
    req_v[0] = 4'b0011;
    cyc();
    check_eq("mid_rst", g_a, 2'b00);
    rst = 1'b0;
    cyc();
    check_eq("post_rst", g_a, 2'b01);

    // randomized phase; requests toggle occasionally so locks persist
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < n_of[k]; i++)
          if ($urandom_range(0, 5) == 0) req_v[k][i] = ~req_v[k][i];
      rst = ($urandom_range(0, 79) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
